sap_ram: RTL and testbench

- 16 x 8 RAM with integrated 4-bit memory address register (MAR) for the SAP-style 8-bit computer.
- Address comes from either front-panel DIP switches or the MAR, which is loaded from the system bus.
- Write data comes from either DIP switches (programming) or the bus (run). Read data is driven onto bus_out under output enable.

---
 rtl/sap_pkg.sv | 18 +
 rtl/sap_mar.sv | 26 ++
 rtl/sap_ram.sv | 65 ++++++
 tb/tb_sap_ram.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared sizing and helpers for the SAP-style RAM slice.
// Imported by the MAR and the RAM top.
package sap_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int RAM_DEPTH = 1 << ADDR_W;

  // 74189-style strobe: manual pulse, or RAM-in during clk high
  function automatic logic write_strobe(
    input logic we_n,
    input logic ctrl,
    input logic clk
  );
    return (~we_n) | (ctrl & clk);
  endfunction

endpackage

// File: rtl/sap_mar.sv
// Memory address register: async reset, async clear, active-low load.
// Clear dominates load; load samples on the rising clock edge.
module sap_mar
  import sap_pkg::*;
#(
  parameter int W = sap_pkg::ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n or posedge clear) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (!load_n) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sap_ram.sv
// 16x8 SAP RAM with integrated MAR, address/data muxes and
// level-sensitive write strobe; read is combinational.
module sap_ram
  import sap_pkg::*;
#(
  parameter int DATA_W = sap_pkg::DATA_W,
  parameter int ADDR_W = sap_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] dipswitch_data,
  input  logic [ADDR_W-1:0] dipswitch_addr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              addr_select,
  input  logic              prog_mode,
  input  logic              write_enable,
  input  logic              output_enable,
  input  logic              control_signal,
  input  logic              load_mar_reg,
  input  logic              clear_mar_reg,
  output logic [DATA_W-1:0] bus_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic [DATA_W-1:0] mem [DEPTH];

  sap_mar #(
    .W (ADDR_W)
  ) u_mar (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear_mar_reg),
    .load_n (load_mar_reg),
    .d      (bus_in[ADDR_W-1:0]),
    .q      (mar)
  );

  assign addr  = addr_select ? dipswitch_addr : mar;
  assign wdata = prog_mode ? bus_in : dipswitch_data;
  assign we    = write_strobe(write_enable, control_signal, clk);

  // Transparent storage: holds whatever was present when we falls
  always_latch begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    bus_out = '0;
    if (rst_n && output_enable) begin
      bus_out = we ? wdata : mem[addr];
    end
  end

endmodule

// File: tb/tb_sap_ram.sv
// Directed self-checking bench for sap_ram.
// Linear stimulus with hand-computed expected read values.
module tb_sap_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dipswitch_data;
  logic [3:0] dipswitch_addr;
  logic [7:0] bus_in;
  logic       addr_select;
  logic       prog_mode;
  logic       write_enable;
  logic       output_enable;
  logic       control_signal;
  logic       load_mar_reg;
  logic       clear_mar_reg;
  logic [7:0] bus_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sap_ram dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dipswitch_data (dipswitch_data),
    .dipswitch_addr (dipswitch_addr),
    .bus_in         (bus_in),
    .addr_select    (addr_select),
    .prog_mode      (prog_mode),
    .write_enable   (write_enable),
    .output_enable  (output_enable),
    .control_signal (control_signal),
    .load_mar_reg   (load_mar_reg),
    .clear_mar_reg  (clear_mar_reg),
    .bus_out        (bus_out)
  );

  task automatic check(input string tag, input logic [7:0] exp);
    n_cmp++;
    assert (bus_out === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, bus_out, exp);
    end
  endtask

  task automatic we_pulse();
    #1 write_enable = 1'b0;
    #1 write_enable = 1'b1;
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    dipswitch_data = 8'h00;
    dipswitch_addr = 4'h0;
    bus_in         = 8'h00;
    addr_select    = 1'b1;
    prog_mode      = 1'b0;
    write_enable   = 1'b1;
    output_enable  = 1'b1;
    control_signal = 1'b0;
    load_mar_reg   = 1'b1;
    clear_mar_reg  = 1'b0;

    #12 check("reset_bus_out", 8'h00);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dipswitch_addr = 4'(i);
      #1 check($sformatf("reset_sweep_%0d", i), 8'h00);
    end
    addr_select = 1'b0;
    #1 check("reset_mar0", 8'h00);

    // Manual program of address 0
    @(negedge clk);
    addr_select    = 1'b1;
    prog_mode      = 1'b0;
    dipswitch_addr = 4'h0;
    dipswitch_data = 8'hCF;
    #1 write_enable = 1'b0;
    #0.5 check("write_through", 8'hCF);
    #0.5 write_enable = 1'b1;
    #1 check("manual_wr0", 8'hCF);

    // Top address is a distinct word
    dipswitch_addr = 4'hF;
    dipswitch_data = 8'h5A;
    we_pulse();
    check("manual_wrF", 8'h5A);
    dipswitch_addr = 4'h0;
    #1 check("no_wrap_0", 8'hCF);

    // Bus-sourced write to address 1
    @(negedge clk);
    prog_mode      = 1'b1;
    bus_in         = 8'hF7;
    dipswitch_addr = 4'h1;
    we_pulse();
    check("bus_wr1", 8'hF7);
    dipswitch_addr = 4'h0;
    #1 check("mem0_kept", 8'hCF);

    // MAR load then hold
    @(negedge clk);
    addr_select  = 1'b0;
    bus_in       = 8'hF1;
    load_mar_reg = 1'b0;
    @(posedge clk);
    #1 load_mar_reg = 1'b1;
    check("mar_load1", 8'hF7);
    bus_in = 8'h05;
    @(posedge clk);
    #1 check("mar_hold", 8'hF7);

    // Async clear, dominating a simultaneous load
    @(negedge clk);
    clear_mar_reg = 1'b1;
    #1 check("mar_clear", 8'hCF);
    load_mar_reg = 1'b0;
    bus_in       = 8'h03;
    @(posedge clk);
    #1 check("clear_over_load", 8'hCF);
    load_mar_reg = 1'b1;
    #1 clear_mar_reg = 1'b0;
    #1 check("clear_release", 8'hCF);

    // Switch address does not disturb MAR
    addr_select    = 1'b1;
    dipswitch_addr = 4'hF;
    #1 check("dip_F", 8'h5A);
    addr_select = 1'b0;
    #1 check("mar_untouched", 8'hCF);

    // Control-unit write into MAR=2
    @(negedge clk);
    bus_in       = 8'h02;
    load_mar_reg = 1'b0;
    @(posedge clk);
    #1 load_mar_reg = 1'b1;
    check("mem2_pre", 8'h00);
    @(negedge clk);
    bus_in         = 8'h3C;
    control_signal = 1'b1;
    #1 check("ctrl_clk_low", 8'h00);
    @(posedge clk);
    #1 check("ctrl_clk_high", 8'h3C);
    @(negedge clk);
    control_signal = 1'b0;
    bus_in         = 8'h00;
    #1 check("ctrl_wr2", 8'h3C);

    output_enable = 1'b0;
    #1 check("oe_off", 8'h00);
    output_enable = 1'b1;
    #1 check("oe_on", 8'h3C);

    // Reset in the middle of a manual write
    @(negedge clk);
    addr_select    = 1'b1;
    prog_mode      = 1'b0;
    dipswitch_addr = 4'h4;
    dipswitch_data = 8'hAA;
    #1 write_enable = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("rst_mid_wr", 8'h00);
    write_enable = 1'b1;
    #1 rst_n = 1'b1;
    #1 check("rst_abort4", 8'h00);
    dipswitch_addr = 4'h0;
    #1 check("rst_clr0", 8'h00);
    dipswitch_addr = 4'h1;
    #1 check("rst_clr1", 8'h00);
    addr_select = 1'b0;
    #1 check("rst_mar", 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
